sequence_encode: RTL and testbench
==================================

Name: sequence_encode

Overview:
- PICC->PCD transmit-side bit encoder for ISO/IEC 14443A at 106 kbit/s. It is the counterpart of the PCD->PICC sequence decoder.
- Accepts a serial bit stream from the upstream frame encoder, which has already inserted parity. Emits a Manchester-coded, subcarrier-modulated load-modulation signal for the AFE.
- Output format: SOC (sequence D), then data (logic 1 = D, logic 0 = E), then EOC (sequence F).
- Runs on the recovered 13.56 MHz carrier clock. The PCD does not pause while the PICC transmits, so the clock is continuous for the whole frame.

Parameters:
- BIT_TICKS, 128, clock ticks per bit period. Power of 2.
- SUBCARRIER_TICKS, 16, clock ticks per subcarrier cycle (fc/16). Power of 2. BIT_TICKS must be a multiple of 2*SUBCARRIER_TICKS.

Ports:
- clk  input  1  13.56 MHz recovered carrier clock; the block's only clock
- rst_n  input  1  asynchronous reset, active low; synchronised deassertion
- in_data  input  1  next bit to send; held stable while in_data_valid=1
- in_data_valid  input  1  in_data holds a bit ready to send; in IDLE, requests a frame start
- in_last  input  1  qualifies in_data as the final bit of the frame
- in_req  output  1  a bit is consumed at the end of this tick if in_data_valid=1
- lm_out  output  1  load modulation enable to the AFE; registered, glitch free
- busy  output  1  frame in progress (SOC through EOC inclusive)
- underrun  output  1  one-tick pulse: in_data_valid was low at a fetch point mid-frame

Behaviour:
- Reset values: lm_out=0, busy=0, underrun=0, in_req=0, state=IDLE, count=0. Reset at any point aborts the frame immediately; no EOC is emitted.
- Tick counter count runs 0..BIT_TICKS-1 within each bit period and wraps to 0 at each period boundary.
- States: IDLE, SOC, DATA, EOC.
- IDLE:
  - lm_out=0, busy=0, in_req=0.
  - Edge with in_data_valid=1 -> SOC, count=0, busy=1. The bit is not consumed.
- SOC: one bit period of sequence D.
- DATA: one bit period per bit; the sequence is D if the latched bit is 1, E if it is 0.
- EOC: one bit period of sequence F. At count=BIT_TICKS-1 -> IDLE, busy=0. A new frame may start on the following edge.
- lm_out pattern, with sc = (count mod SUBCARRIER_TICKS) < SUBCARRIER_TICKS/2:
  - D: lm_out = sc && count < BIT_TICKS/2
  - E: lm_out = sc && count >= BIT_TICKS/2
  - F, IDLE: lm_out = 0
  - lm_out is updated on the same edge as state and count, so its first tick is high on entry to SOC.
- Fetch point: count=BIT_TICKS-1 in SOC, or in DATA when the current bit is not last.
  - in_req=1 only at a fetch point. It is decoded combinationally from registers only.
  - in_req && in_data_valid -> latch in_data and in_last, next state DATA, count=0.
  - in_req && !in_data_valid -> next state EOC, underrun pulses for 1 tick, count=0.
- After the bit with in_last=1 completes its period -> EOC. in_req stays 0.
- in_data_valid outside fetch points is ignored while busy.
- Total frame length is (N+2)*BIT_TICKS ticks for N data bits.
- Zero-bit frame: SOC followed by an immediate underrun at the first fetch point -> EOC, with underrun pulsed.

Optional Feature:
- Macro: SEQUENCE_ENCODE_SEQ_OUT_EN.
- Defined: adds output port seq_out [1:0], registered and aligned with lm_out. Encoding: 0=IDLE/none, 1=D, 2=E, 3=F. Used by the bench and for debug.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Idle stimulus: hold in_data_valid=0 for 1000 ticks -> lm_out=0, busy=0, in_req=0 throughout.
- Single bit: valid=1 with in_data=1, in_last=1 -> 128 ticks of D; in_req high at tick 127; 128 ticks of D; 128 ticks of F; busy low after 384 ticks. During each D, lm_out is high on ticks 0-7, 16-23, 32-39 and 48-55 only.
- Byte 0xA5 LSB first plus parity bit 1, last on parity -> SOC then D,E,D,E,E,D,E,D,D then F. 9 in_req pulses spaced 128 ticks apart. Frame length 11*128 ticks.
- Underrun: 3 bits sent, then valid dropped at the 4th fetch -> underrun pulses once at that tick, followed by F for 128 ticks, then IDLE, then busy=0.
- Back-to-back frames: valid held high at the IDLE return -> the new SOC starts 1 tick after busy falls, with no extra gap.
- Reset mid-frame: assert rst_n=0 during tick 70 of a D period -> lm_out, busy and in_req go low immediately (asynchronously). After release, the block stays IDLE until valid is asserted.

Source files
------------

// File: rtl/sequence_encode_if.sv
// Serial bit handshake between the upstream frame encoder and sequence_encode.
// The master drives the bit stream; the slave (the encoder) returns the fetch request.
interface sequence_encode_if;
  logic in_data;
  logic in_data_valid;
  logic in_last;
  logic in_req;

  modport master (
    output in_data,
    output in_data_valid,
    output in_last,
    input  in_req
  );

  modport slave (
    input  in_data,
    input  in_data_valid,
    input  in_last,
    output in_req
  );
endinterface

// File: rtl/sequence_encode.sv
// ISO/IEC 14443A PICC->PCD bit encoder at 106 kbit/s.
// Frame: SOC (sequence D), one D (bit 1) or E (bit 0) per data bit, then EOC (sequence F).
// D/E are Manchester halves filled with the fc/SUBCARRIER_TICKS subcarrier.
// rst_n is expected to arrive with its deassertion already synchronised to clk.
// Optional build macro SEQUENCE_ENCODE_SEQ_OUT_EN adds the seq_out debug port
// (0 = none, 1 = D, 2 = E, 3 = F), registered and aligned with lm_out.
module sequence_encode #(
  parameter int BIT_TICKS        = 128,
  parameter int SUBCARRIER_TICKS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  sequence_encode_if.slave   up,
  output logic               lm_out,
  output logic               busy,
  output logic               underrun
`ifdef SEQUENCE_ENCODE_SEQ_OUT_EN
  ,
  output logic [1:0]         seq_out
`endif
);

  localparam int CW  = $clog2(BIT_TICKS);
  localparam int SCW = $clog2(SUBCARRIER_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  localparam logic [1:0] SEQ_NONE = 2'd0;
  localparam logic [1:0] SEQ_D    = 2'd1;
  localparam logic [1:0] SEQ_E    = 2'd2;
  localparam logic [1:0] SEQ_F    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOC  = 2'd1,
    DATA = 2'd2,
    EOC  = 2'd3
  } state_t;

  state_t        state_r, state_next;
  logic [CW-1:0] count_r, count_next;
  logic          bit_r, bit_next;
  logic          last_r, last_next;
  logic          lm_r, lm_next;
  logic          busy_r;
  logic          underrun_r, underrun_next;
  logic [1:0]    seq_next;
  logic          fetch_s;

  // Modulation level for a sequence: subcarrier-on phase gated to the proper bit half.
  function automatic logic seq_level(input logic [1:0] seq, input logic sc_off, input logic second_half);
    logic lvl;
    case (seq)
      SEQ_D:   lvl = !sc_off && !second_half;
      SEQ_E:   lvl = !sc_off && second_half;
      default: lvl = 1'b0;
    endcase
    return lvl;
  endfunction

  // Fetch point: end of SOC, or end of a data bit that is not the last one.
  assign fetch_s   = (count_r == CNT_LAST) &&
                     ((state_r == SOC) || ((state_r == DATA) && !last_r));
  assign up.in_req = fetch_s;

  // Next-state, tick counter and bit-latch decode.
  always_comb begin
    state_next    = state_r;
    count_next    = count_r + CW'(1);
    bit_next      = bit_r;
    last_next     = last_r;
    underrun_next = 1'b0;
    case (state_r)
      IDLE: begin
        count_next = CNT_ZERO;
        if (up.in_data_valid) begin
          state_next = SOC;
        end else begin
          state_next = IDLE;
        end
      end
      SOC, DATA: begin
        if (count_r == CNT_LAST) begin
          count_next = CNT_ZERO;
          if (fetch_s) begin
            if (up.in_data_valid) begin
              bit_next   = up.in_data;
              last_next  = up.in_last;
              state_next = DATA;
            end else begin
              state_next    = EOC;
              underrun_next = 1'b1;
            end
          end else begin
            state_next = EOC;
          end
        end else begin
          state_next = state_r;
        end
      end
      EOC: begin
        if (count_r == CNT_LAST) begin
          count_next = CNT_ZERO;
          state_next = IDLE;
        end else begin
          state_next = EOC;
        end
      end
      default: begin
        count_next = CNT_ZERO;
        state_next = IDLE;
      end
    endcase
  end

  // Sequence to be emitted in the next tick and its modulation level.
  always_comb begin
    seq_next = SEQ_NONE;
    case (state_next)
      IDLE:    seq_next = SEQ_NONE;
      SOC:     seq_next = SEQ_D;
      DATA:    seq_next = bit_next ? SEQ_D : SEQ_E;
      EOC:     seq_next = SEQ_F;
      default: seq_next = SEQ_NONE;
    endcase
    lm_next = seq_level(seq_next, count_next[SCW-1], count_next[CW-1]);
  end

  // State, counter, latched bit and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      count_r    <= CNT_ZERO;
      bit_r      <= 1'b0;
      last_r     <= 1'b0;
      lm_r       <= 1'b0;
      busy_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_next;
      count_r    <= count_next;
      bit_r      <= bit_next;
      last_r     <= last_next;
      lm_r       <= lm_next;
      busy_r     <= (state_next != IDLE);
      underrun_r <= underrun_next;
    end
  end

  assign lm_out   = lm_r;
  assign busy     = busy_r;
  assign underrun = underrun_r;

`ifdef SEQUENCE_ENCODE_SEQ_OUT_EN
  logic [1:0] seq_r;

  // Debug sequence code, registered on the same edge as lm_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_r <= SEQ_NONE;
    end else begin
      seq_r <= seq_next;
    end
  end

  assign seq_out = seq_r;
`endif

endmodule

// File: tb/tb_sequence_encode.sv
// Scoreboard bench for sequence_encode: each frame's expected symbol string,
// fetch count and underrun timing is queued before the stimulus; a monitor
// classifies every observed bit period of lm_out and compares at frame end.
module tb_sequence_encode;
  localparam int BT = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lm_out, busy, underrun;
`ifdef SEQUENCE_ENCODE_SEQ_OUT_EN
  logic [1:0] seq_out;
`endif

  sequence_encode_if bus();

  sequence_encode #(.BIT_TICKS(BT), .SUBCARRIER_TICKS(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up       (bus),
    .lm_out   (lm_out),
    .busy     (busy),
    .underrun (underrun)
`ifdef SEQUENCE_ENCODE_SEQ_OUT_EN
    ,
    .seq_out  (seq_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    string syms;
    int    nreq;
    int    und_tick;
    int    gap;
  } exp_t;

  exp_t exp_q[$];
  logic [BT-1:0] d_pat, e_pat;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic void check_str(input string name, input string act, input string req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%s required=%s", name, act, req);
    end
  endfunction

  function automatic string classify(input logic [BT-1:0] p);
    if (p == d_pat) return "D";
    else if (p == e_pat) return "E";
    else if (p == {BT{1'b0}}) return "F";
    else return "?";
  endfunction

  task automatic push_exp(input string s, input int nreq, input int und, input int gap);
    exp_t e;
    e.syms = s; e.nreq = nreq; e.und_tick = und; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // bits[k] is sent at fetch k; at fetch drop_at valid is held low instead.
  task automatic send_frame(input logic [31:0] bits, input int n, input int drop_at, input bit hold);
    int nf;
    int prev;
    int w;
    nf = (drop_at >= 0) ? drop_at + 1 : n;
    prev = 0;
    for (int k = 0; k < nf; k++) begin
      w = 0;
      if (k == drop_at) begin
        if (k == 0) begin
          bus.in_data_valid = 1'b1;
          @(negedge clk);
        end
        bus.in_data_valid = 1'b0;
      end else begin
        bus.in_data       = bits[k];
        bus.in_last       = (k == n - 1);
        bus.in_data_valid = 1'b1;
      end
      while (bus.in_req !== 1'b1 && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (w >= 400) check("req_timeout", w, 0);
      else if (k > 0) check("req_spacing", cyc - prev, BT);
      prev = cyc;
      @(negedge clk);
    end
    if (!hold) begin
      bus.in_data_valid = 1'b0;
      w = 0;
      while (busy && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 2000) check("busy_timeout", w, 0);
      repeat (5) @(negedge clk);
    end
  endtask

  // Monitor: records each bit period of lm_out and scores the frame when busy falls.
  initial begin
    bit in_frame;
    int t, nreq, und_t, und_n, idle;
    string obs;
    logic [BT-1:0] pat;
    exp_t e;
    in_frame = 1'b0; t = 0; nreq = 0; und_t = -1; und_n = 0; idle = 0; obs = ""; pat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        in_frame = 1'b0;
        idle = 0;
      end else if (busy) begin
        if (!in_frame) begin
          in_frame = 1'b1; t = 0; obs = ""; nreq = 0; und_t = -1; und_n = 0;
          if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
          else if (exp_q[0].gap >= 0) check("idle_gap", idle, exp_q[0].gap);
        end
        pat[t % BT] = lm_out;
        if (bus.in_req) nreq++;
        if (underrun) begin
          und_n++;
          und_t = t;
        end
        if (t % BT == BT - 1) obs = {obs, classify(pat)};
        t++;
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            check("frame_unexpected_end", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_str("symbols", obs, e.syms);
            check("frame_ticks", t, e.syms.len() * BT);
            check("req_count", nreq, e.nreq);
            check("underrun_tick", und_t, e.und_tick);
            check("underrun_count", und_n, (e.und_tick >= 0) ? 1 : 0);
          end
          idle = 0;
        end
        idle++;
      end
    end
  end

  // Stimulus.
  initial begin
    int bad;
    int w;
    for (int i = 0; i < BT; i++) begin
      d_pat[i] = ((i % 16) < 8) && (i < BT / 2);
      e_pat[i] = ((i % 16) < 8) && (i >= BT / 2);
    end
    bus.in_data = 1'b0; bus.in_data_valid = 1'b0; bus.in_last = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lm_out", lm_out, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_in_req", bus.in_req, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (lm_out || busy || bus.in_req || underrun) bad++;
    end
    check("idle_quiet", bad, 0);

    // Single bit 1, last.
    push_exp("DDF", 1, -1, -1);
    send_frame(32'h1, 1, -1, 1'b0);
    // 0xA5 LSB first plus parity 1.
    push_exp("DDEDEEDEDDF", 9, -1, -1);
    send_frame(32'h1A5, 9, -1, 1'b0);
    // Bits 0,1,1 then no data at the 4th fetch.
    push_exp("DEDDF", 4, 512, -1);
    send_frame(32'h6, 4, 3, 1'b0);
    // Zero-bit frame.
    push_exp("DF", 1, 128, -1);
    send_frame(32'h0, 1, 0, 1'b0);
    // Back-to-back: single 0, then 1,0 with valid held across the IDLE return.
    push_exp("DEF", 1, -1, -1);
    push_exp("DDEF", 2, -1, 1);
    send_frame(32'h0, 1, -1, 1'b1);
    send_frame(32'h1, 2, -1, 1'b0);
    check("frames_left", exp_q.size(), 0);

    // Reset during tick 70 of a D data period.
    mon_en = 1'b0;
    bus.in_data = 1'b1; bus.in_last = 1'b1; bus.in_data_valid = 1'b1;
    w = 0;
    while (!busy && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("rst_test_start", busy, 1);
    repeat (BT + 70) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_lm_out", lm_out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_in_req", bus.in_req, 0);
    bus.in_data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy || lm_out || bus.in_req) bad++;
    end
    check("post_rst_idle", bad, 0);
    bus.in_data_valid = 1'b1;
    @(negedge clk);
    check("post_rst_restart", busy, 1);
    check("post_rst_lm_first", lm_out, 1);
    bus.in_data_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
